// File: rtl/nios2_cpu_mul_seq.sv
// nios2_cpu_mul_seq: multi-cycle 32x32 unsigned multiply sequencer built
// around one registered 16x16 multiplier. Partial products LL, LH, HL and
// (optionally) HH are issued on successive cycles and summed into an
// accumulator one cycle after issue.
// Optional feature macro: NIOS2_MUL_SEQ_HIGH_EN enables the HH pass, the M3
// state and the upper 32 accumulator bits (rsp_hi). Without it rsp_hi is 0.
module nios2_cpu_mul_seq (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic [31:0] req_src1,
    input  logic [31:0] req_src2,
    input  logic        req_high,
    input  logic        abort,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [31:0] rsp_lo,
    output logic [31:0] rsp_hi,
    output logic        busy
);

    localparam int unsigned OP_W    = 32;
    localparam int unsigned SLICE_W = 16;
`ifdef NIOS2_MUL_SEQ_HIGH_EN
    localparam int unsigned ACC_W   = 64;
`else
    localparam int unsigned ACC_W   = 32;
`endif

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        M0   = 3'd1,
        M1   = 3'd2,
        M2   = 3'd3,
        M3   = 3'd4,
        ACC  = 3'd5,
        DONE = 3'd6
    } state_t;

    state_t             state_q, state_d;
    logic [OP_W-1:0]    a_q, a_d;
    logic [OP_W-1:0]    b_q, b_d;
    logic [OP_W-1:0]    prod_q, prod_d;
    logic [ACC_W-1:0]   acc_q, acc_d;
    logic               rsp_valid_q, rsp_valid_d;
    logic [OP_W-1:0]    rsp_lo_q, rsp_lo_d;

    logic               accept_c;
    logic [SLICE_W-1:0] mul_a_c;
    logic [SLICE_W-1:0] mul_b_c;
    logic [OP_W-1:0]    mul_prod_c;
    logic [ACC_W-1:0]   addend_c;
    logic [ACC_W-1:0]   acc_sum_c;

`ifdef NIOS2_MUL_SEQ_HIGH_EN
    logic               run_hh_q, run_hh_d;
    logic [OP_W-1:0]    rsp_hi_q, rsp_hi_d;
`else
    logic               unused_req_high;
    assign unused_req_high = req_high;
`endif

    assign req_ready = (state_q == IDLE) & ~abort;
    assign busy      = (state_q != IDLE);
    assign accept_c  = req_valid & req_ready;
    assign rsp_valid = rsp_valid_q;
    assign rsp_lo    = rsp_lo_q;
`ifdef NIOS2_MUL_SEQ_HIGH_EN
    assign rsp_hi    = rsp_hi_q;
`else
    assign rsp_hi    = '0;
`endif

    // Operand half selection for the shared 16x16 multiplier.
    always_comb begin
        mul_a_c = a_q[SLICE_W-1:0];
        mul_b_c = b_q[SLICE_W-1:0];
        if (state_q == M2 || state_q == M3) mul_a_c = a_q[OP_W-1:SLICE_W];
        if (state_q == M1 || state_q == M3) mul_b_c = b_q[OP_W-1:SLICE_W];
        mul_prod_c = OP_W'(mul_a_c) * OP_W'(mul_b_c);
    end

    // Shift the registered partial product into place for the current add.
    always_comb begin
        addend_c = '0;
        case (state_q)
            M1:     addend_c = ACC_W'(prod_q);
            M2, M3: addend_c = ACC_W'({prod_q, 16'h0000});
`ifdef NIOS2_MUL_SEQ_HIGH_EN
            ACC:    addend_c = run_hh_q ? ACC_W'({prod_q, 32'h0000_0000})
                                        : ACC_W'({prod_q, 16'h0000});
`else
            ACC:    addend_c = ACC_W'({prod_q, 16'h0000});
`endif
            default: addend_c = '0;
        endcase
        acc_sum_c = acc_q + addend_c;
    end

    // Next-state and datapath update; abort overrides any non-idle progress.
    always_comb begin
        state_d  = state_q;
        a_d      = a_q;
        b_d      = b_q;
        prod_d   = prod_q;
        acc_d    = acc_q;
        rsp_lo_d = rsp_lo_q;
`ifdef NIOS2_MUL_SEQ_HIGH_EN
        run_hh_d = run_hh_q;
        rsp_hi_d = rsp_hi_q;
`endif
        case (state_q)
            IDLE: begin
                if (accept_c) begin
                    a_d     = req_src1;
                    b_d     = req_src2;
                    acc_d   = '0;
`ifdef NIOS2_MUL_SEQ_HIGH_EN
                    run_hh_d = req_high;
`endif
                    state_d = M0;
                end
            end
            M0: begin
                prod_d  = mul_prod_c;
                state_d = M1;
            end
            M1: begin
                prod_d  = mul_prod_c;
                acc_d   = acc_sum_c;
                state_d = M2;
            end
            M2: begin
                prod_d  = mul_prod_c;
                acc_d   = acc_sum_c;
`ifdef NIOS2_MUL_SEQ_HIGH_EN
                state_d = run_hh_q ? M3 : ACC;
`else
                state_d = ACC;
`endif
            end
            M3: begin
`ifdef NIOS2_MUL_SEQ_HIGH_EN
                prod_d  = mul_prod_c;
                acc_d   = acc_sum_c;
                state_d = ACC;
`else
                state_d = IDLE;
`endif
            end
            ACC: begin
                acc_d    = acc_sum_c;
                rsp_lo_d = acc_sum_c[OP_W-1:0];
`ifdef NIOS2_MUL_SEQ_HIGH_EN
                rsp_hi_d = run_hh_q ? acc_sum_c[ACC_W-1:OP_W] : '0;
`endif
                state_d  = DONE;
            end
            DONE: begin
                if (rsp_ready) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
        if (abort && state_q != IDLE) state_d = IDLE;
        rsp_valid_d = (state_d == DONE);
    end

    // State register.
    always_ff @(posedge clk) begin
        if (!reset_n) state_q <= IDLE;
        else          state_q <= state_d;
    end

    // Operand, product, accumulator and response registers.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            a_q         <= '0;
            b_q         <= '0;
            prod_q      <= '0;
            acc_q       <= '0;
            rsp_valid_q <= 1'b0;
            rsp_lo_q    <= '0;
`ifdef NIOS2_MUL_SEQ_HIGH_EN
            run_hh_q    <= 1'b0;
            rsp_hi_q    <= '0;
`endif
        end else begin
            a_q         <= a_d;
            b_q         <= b_d;
            prod_q      <= prod_d;
            acc_q       <= acc_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_lo_q    <= rsp_lo_d;
`ifdef NIOS2_MUL_SEQ_HIGH_EN
            run_hh_q    <= run_hh_d;
            rsp_hi_q    <= rsp_hi_d;
`endif
        end
    end

endmodule
